// File: rtl/bit_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : bit_logic_unit
// Brief    : Multi-cycle bitwise logic unit (AND/OR/XOR/NOR). The operands are
//            processed SLICE bits per clock, so one narrow logic slice serves a
//            WIDTH-bit operation. Operands use a valid/ready handshake, and so
//            does the result.
// Options  : define ZERO_FLAG_EN to add the sticky 'zero' result flag port.
// Revision : 1.0 - initial release
// ============================================================================
module bit_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             busy
`ifdef ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    // Stop elaboration if the operand width does not split into whole slices.
    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("bit_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   result_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_slice;

    // Gating with reset_n keeps the unit from offering to accept while in reset.
    assign in_ready  = (state_q == ST_IDLE) & reset_n;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Result    = result_q;

    // Last slice wraps the counter to zero even when NSLICE is not a power of two.
    assign cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);

    // Select the current slice of the latched operands and apply the latched opcode.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                w_a_slice = a_q[s*SLICE +: SLICE];
                w_b_slice = b_q[s*SLICE +: SLICE];
            end
        end
        case (op_q)
            OP_AND:  w_slice = w_a_slice & w_b_slice;
            OP_OR:   w_slice = w_a_slice | w_b_slice;
            OP_XOR:  w_slice = w_a_slice ^ w_b_slice;
            default: w_slice = ~(w_a_slice | w_b_slice);
        endcase
    end

    // Control FSM, which also writes the result one slice per BUSY cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        op_q     <= op;
                        result_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int s = 0; s < NSLICE; s++) begin
                        if (cnt_q == CNT_W'(s)) begin
                            result_q[s*SLICE +: SLICE] <= w_slice;
                        end
                    end
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_CNT) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ZERO_FLAG_EN
    logic zero_q;

    assign zero = zero_q;

    // Sticky zero flag: armed on accept, then cleared by any non-zero slice.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && in_valid) begin
            zero_q <= 1'b1;
        end else if (state_q == ST_BUSY) begin
            zero_q <= zero_q & (w_slice == '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_logic_unit
// Brief    : Directed plus random bench for bit_logic_unit. Each accepted
//            operation queues its expected result. The expected result is
//            popped and compared when the unit presents out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_logic_unit;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [1:0]        op        = 2'b00;
    logic [WIDTH-1:0]  A         = '0;
    logic [WIDTH-1:0]  B         = '0;
    wire               in_ready;
    wire               out_valid;
    wire               busy;
    wire [WIDTH-1:0]   Result;
`ifdef ZERO_FLAG_EN
    wire               zero;
`endif

    int                n_vec = 0;
    int                n_err = 0;
    logic [WIDTH-1:0]  exp_q[$];

    bit_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
`ifdef ZERO_FLAG_EN
        .zero      (zero),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Reference model of the four operations.
    function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operation. Returns at the falling edge just after the accept edge.
    task automatic send(input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("send_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        A = a;
        B = b;
        exp_q.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        op = 2'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Wait for out_valid, check the latency, then pop the expected value and compare it.
    task automatic collect(input string tag);
        int cyc = 0;
        logic [WIDTH-1:0] e;
        while (!out_valid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(NSLICE));
        e = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_result"}, Result, e);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},   32'(in_ready),  32'd1);
        check({tag, "_busy_clr"},   32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] held;
        logic [1:0]       ro;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Power-on reset held for two edges.
        repeat (2) @(negedge clock);
        check("rst_result",   Result,           32'h0);
        check("rst_ovalid",   32'(out_valid),   32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_in_ready", 32'(in_ready),    32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // OR, including the latency check.
        send(2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        collect("or");
        release_out("or");

        // AND / XOR / NOR on the same operands.
        send(2'b00, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFF00_0000);
        collect("and");
        release_out("and");
        send(2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
        collect("xor");
        release_out("xor");
        send(2'b11, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0000_00FF);
        collect("nor");
        release_out("nor");
        check("idle_result_held", Result, 32'h0000_00FF);

        // Reset held for two cycles while idle, with a non-zero Result beforehand.
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_rst_result", Result,         32'h0);
        check("idle_rst_ovalid", 32'(out_valid), 32'd0);
        check("idle_rst_busy",   32'(busy),      32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_rst_in_ready", 32'(in_ready), 32'd1);

        // Hold off the consumer in DONE while new operands are offered.
        send(2'b10, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'hAAAA_AAAA);
        collect("stall");
        held = 32'hAAAA_AAAA;
        in_valid = 1'b1;
        op = 2'b01;
        A = 32'h1111_1111;
        B = 32'h2222_2222;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall_ovalid",   32'(out_valid), 32'd1);
            check("stall_result",   Result,         held);
            check("stall_in_ready", 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        release_out("stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_not_taken_busy", 32'(busy), 32'd0);
            check("stall_keep_result",    Result,    held);
        end

        // Reset after two BUSY slices abandons the operation.
        send(2'b01, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        void'(exp_q.pop_front());
        check("abort_result", Result,         32'h0);
        check("abort_ovalid", 32'(out_valid), 32'd0);
        check("abort_busy",   32'(busy),      32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("abort_no_ovalid", 32'(out_valid), 32'd0);
        end

        // Zero-result case and its complement.
        send(2'b00, 32'h1234_5678, 32'hEDCB_A987, 32'h0000_0000);
        collect("zand");
`ifdef ZERO_FLAG_EN
        check("zand_flag", 32'(zero), 32'd1);
`endif
        release_out("zand");
        send(2'b01, 32'h1234_5678, 32'hEDCB_A987, 32'hFFFF_FFFF);
        collect("zor");
`ifdef ZERO_FLAG_EN
        check("zor_flag", 32'(zero), 32'd0);
`endif
        release_out("zor");

        // Random operations checked against the reference model.
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            send(ro, ra, rb, model(ro, ra, rb));
            collect("rand");
            release_out("rand");
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
